// File: rtl/video_timing_lock_pkg.sv
// Shared types, widths and helpers for the video timing lock block.
package vtl_pkg;

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned ERR_W   = 8;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [ERR_W-1:0]   err_t;

   function automatic coord_t coord_inc(coord_t v);
      return (v == '1) ? v : v + coord_t'(1);
   endfunction

endpackage

// File: rtl/video_timing_lock_edge_det.sv
// Rise/fall detector: compares the live input against its registered previous sample.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b0;
      else     prev <= sig;
   end

   assign rise = sig & ~prev;
   assign fall = ~sig & prev;

endmodule

// File: rtl/video_timing_lock.sv
// Two-stage video pass-through with pixel coordinates, frame/line markers and a
// 1080p geometry checker driving a SEARCH/ACQUIRE/LOCKED lock machine.
module video_timing_lock
   import vtl_pkg::*;
#(
   parameter int unsigned H_WIDTH     = 1920,
   parameter int unsigned H_TOTAL     = 2200,
   parameter int unsigned V_HEIGHT    = 1080,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               vs_i,
   input  logic               hs_i,
   input  logic               de_i,
   input  logic [23:0]        data_i,
   output logic               vs_o,
   output logic               hs_o,
   output logic               de_o,
   output logic [23:0]        data_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               sof_o,
   output logic               eol_o,
   output logic               locked_o,
   output logic [ERR_W-1:0]   err_cnt_o
);

   localparam coord_t     H_WIDTH_C  = coord_t'(H_WIDTH);
   localparam coord_t     H_TOTAL_C  = coord_t'(H_TOTAL);
   localparam coord_t     V_HEIGHT_C = coord_t'(V_HEIGHT);
   localparam logic [3:0] LOCK_N     = 4'(LOCK_FRAMES);

   logic vs_rise, vs_fall, hs_rise, hs_fall, de_rise, de_fall;
   logic unused_edges;

   edge_det u_vs_edge (.clk(clk_i), .rst(rst_i), .sig(vs_i), .rise(vs_rise), .fall(vs_fall));
   edge_det u_hs_edge (.clk(clk_i), .rst(rst_i), .sig(hs_i), .rise(hs_rise), .fall(hs_fall));
   edge_det u_de_edge (.clk(clk_i), .rst(rst_i), .sig(de_i), .rise(de_rise), .fall(de_fall));

   assign unused_edges = vs_fall ^ hs_fall ^ de_rise;

   state_t      state;
   logic [3:0]  good_cnt, good_nxt;
   coord_t      x_cnt, y_cnt, h_cnt, lines_now;
   logic        armed, frame_bad, sof_pend;
   logic        line_bad, period_bad, frame_bad_now;

   // First pipeline stage; the second stage is the output registers.
   logic        vs_s1, hs_s1, de_s1, sof_s1;
   logic [23:0] data_s1;
   coord_t      x_s1, y_s1;

   // A line ending on the same edge as vs still belongs to the frame being judged.
   always_comb begin
      lines_now     = de_fall ? coord_inc(y_cnt) : y_cnt;
      line_bad      = de_fall && (x_cnt != H_WIDTH_C);
      period_bad    = hs_rise && armed && (h_cnt != H_TOTAL_C);
      frame_bad_now = frame_bad || line_bad || period_bad || (lines_now != V_HEIGHT_C);
      good_nxt      = good_cnt + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_s1     <= 1'b0;
         hs_s1     <= 1'b0;
         de_s1     <= 1'b0;
         sof_s1    <= 1'b0;
         data_s1   <= '0;
         x_s1      <= '0;
         y_s1      <= '0;
         vs_o      <= 1'b0;
         hs_o      <= 1'b0;
         de_o      <= 1'b0;
         data_o    <= '0;
         x_o       <= '0;
         y_o       <= '0;
         sof_o     <= 1'b0;
         eol_o     <= 1'b0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         h_cnt     <= '0;
         armed     <= 1'b0;
         frame_bad <= 1'b0;
         sof_pend  <= 1'b0;
      end else begin
         vs_s1   <= vs_i;
         hs_s1   <= hs_i;
         de_s1   <= de_i;
         data_s1 <= data_i;
         x_s1    <= x_cnt;
         y_s1    <= y_cnt;
         sof_s1  <= de_i && (sof_pend || vs_rise) && (state != SEARCH);

         vs_o   <= vs_s1;
         hs_o   <= hs_s1;
         de_o   <= de_s1;
         data_o <= data_s1;
         x_o    <= x_s1;
         y_o    <= y_s1;
         sof_o  <= sof_s1;
         // de_i low now means the pixel in stage 1 was the last of its line.
         eol_o  <= de_fall;

         x_cnt <= de_i ? coord_inc(x_cnt) : '0;

         if (vs_rise)      y_cnt <= '0;
         else if (de_fall) y_cnt <= coord_inc(y_cnt);

         if (vs_rise)   sof_pend <= 1'b1;
         else if (de_i) sof_pend <= 1'b0;

         h_cnt <= hs_rise ? coord_t'(1) : coord_inc(h_cnt);

         if (state == SEARCH) armed <= 1'b0;
         else if (hs_rise)    armed <= 1'b1;

         if ((state == SEARCH) || vs_rise) frame_bad <= 1'b0;
         else if (line_bad || period_bad)  frame_bad <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= SEARCH;
         good_cnt  <= '0;
         err_cnt_o <= '0;
         locked_o  <= 1'b0;
      end else if (vs_rise) begin
         unique case (state)
            SEARCH: begin
               state    <= ACQUIRE;
               good_cnt <= '0;
            end
            ACQUIRE: begin
               if (!frame_bad_now) begin
                  good_cnt <= good_nxt;
                  if (good_nxt >= LOCK_N) begin
                     state    <= LOCKED;
                     locked_o <= 1'b1;
                  end
               end else begin
                  good_cnt <= '0;
                  if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + err_t'(1);
               end
            end
            LOCKED: begin
               if (frame_bad_now) begin
                  state    <= ACQUIRE;
                  locked_o <= 1'b0;
                  good_cnt <= '0;
                  if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + err_t'(1);
               end
            end
            default: begin
               state    <= SEARCH;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_timing_lock.sv
// Directed bench: synthetic small frames, per-cycle scoreboard on the stream and a
// small lock/error model checked at every frame start.
module tb_video_timing_lock;

   localparam int unsigned HW = 8;
   localparam int unsigned HT = 16;
   localparam int unsigned VH = 4;
   localparam int unsigned LF = 2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
   logic [23:0] data_i = '0;
   logic        vs_o, hs_o, de_o, sof_o, eol_o, locked_o;
   logic [23:0] data_o;
   logic [11:0] x_o, y_o;
   logic [7:0]  err_cnt_o;

   always #5 clk_i = ~clk_i;

   video_timing_lock #(
      .H_WIDTH(HW), .H_TOTAL(HT), .V_HEIGHT(VH), .LOCK_FRAMES(LF)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .data_i(data_i),
      .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o), .x_o(x_o), .y_o(y_o),
      .sof_o(sof_o), .eol_o(eol_o), .locked_o(locked_o), .err_cnt_o(err_cnt_o)
   );

   typedef struct packed {
      logic        vs, hs, de;
      logic [23:0] data;
      logic [11:0] x, y;
      logic        sof;
   } exp_t;

   exp_t q[$];
   exp_t e_m;
   logic eol_m;
   bit   sb_en = 1'b0;
   int   n_tests = 0, n_fail = 0;

   // Lock model: 0 search, 1 acquire, 2 locked.
   int   m_state = 0, m_good = 0, m_err = 0;
   bit   m_prev_bad = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic d, input logic [23:0] dat,
                        input logic [11:0] x, input logic [11:0] y, input logic s);
      vs_i = v; hs_i = h; de_i = d; data_i = dat;
      if (sb_en) q.push_back('{vs: v, hs: h, de: d, data: dat, x: x, y: y, sof: s});
      @(posedge clk_i); #1;
   endtask

   task automatic send_line(input logic v, input int period, input int de_len, input int row,
                            input logic sof_first, input int c_from, input int c_to);
      logic        act;
      logic [11:0] xx, yy;
      for (int c = c_from; c < c_to; c++) begin
         act = (c >= 4) && (c < 4 + de_len);
         xx  = act ? 12'(c - 4) : 12'd0;
         yy  = act ? 12'(row) : 12'd0;
         drive(v, (c < 2), act, act ? {yy, xx} : 24'($urandom), xx, yy,
               sof_first && act && (c == 4));
      end
      if (period < 0) $fatal(1, "FAIL send_line: bad period %0d", period);
   endtask

   task automatic model_vs();
      case (m_state)
         0: begin m_state = 1; m_good = 0; end
         1: begin
            if (!m_prev_bad) begin
               m_good++;
               if (m_good >= LF) m_state = 2;
            end else begin
               m_good = 0;
               if (m_err < 255) m_err++;
            end
         end
         default: begin
            if (m_prev_bad) begin
               m_state = 1; m_good = 0;
               if (m_err < 255) m_err++;
            end
         end
      endcase
   endtask

   // Frame: vs line, blank line, n_act active lines, blank line.
   task automatic send_frame(input int n_act, input int bad_w, input int bad_p);
      int per, len;
      bit act;
      check("lock_pre", 64'(locked_o), 64'(m_state == 2));
      model_vs();
      for (int li = 0; li < n_act + 3; li++) begin
         per = (li == bad_p) ? 17 : 16;
         act = (li >= 2) && (li < n_act + 2);
         len = !act ? 0 : ((li - 2 == bad_w) ? 7 : 8);
         if (li == 0) begin
            send_line(1'b1, per, 0, 0, 1'b0, 0, 1);
            check("lock_vs", 64'(locked_o), 64'(m_state == 2));
            check("err_vs", 64'(err_cnt_o), 64'(m_err));
            send_line(1'b1, per, 0, 0, 1'b0, 1, per);
         end else begin
            send_line(1'b0, per, len, li - 2, act && (li == 2), 0, per);
         end
      end
      m_prev_bad = (n_act != VH) || (bad_w >= 0) || (bad_p >= 0);
   endtask

   always @(negedge clk_i) begin
      if (sb_en && q.size() >= 3) begin
         e_m   = q.pop_front();
         eol_m = e_m.de && !q[0].de;
         check("stream", 64'({vs_o, hs_o, de_o, data_o, sof_o, eol_o}),
               64'({e_m.vs, e_m.hs, e_m.de, e_m.data, e_m.sof, eol_m}));
         if (e_m.de) check("coord", 64'({x_o, y_o}), 64'({e_m.x, e_m.y}));
      end
   end

   initial begin
      // Reset held with random inputs.
      for (int i = 0; i < 8; i++) begin
         vs_i = 1'($urandom); hs_i = 1'($urandom); de_i = 1'($urandom);
         data_i = 24'($urandom);
         @(posedge clk_i); #1;
         check("rst_outs", 64'({vs_o, hs_o, de_o, data_o, x_o, y_o, sof_o, eol_o, locked_o,
                               err_cnt_o}), 64'd0);
      end
      rst_i = 1'b0;
      drive(0, 0, 0, 24'd0, 12'd0, 12'd0, 0);
      check("rel_lock", 64'(locked_o), 64'd0);
      check("rel_err", 64'(err_cnt_o), 64'd0);
      repeat (3) drive(0, 0, 0, 24'd0, 12'd0, 12'd0, 0);

      // Bad geometry while searching is ignored; no sof before a vs edge.
      sb_en = 1'b1;
      send_line(1'b0, 17, 7, 0, 1'b0, 0, 17);
      send_line(1'b0, 16, 8, 1, 1'b0, 0, 16);
      send_line(1'b0, 16, 0, 0, 1'b0, 0, 16);

      // Three clean frames: lock on the third vs edge.
      repeat (3) send_frame(4, -1, -1);
      check("lock_f3", 64'(locked_o), 64'd1);
      check("err_f3", 64'(err_cnt_o), 64'd0);

      // Short line drops lock; two clean frames relock.
      send_frame(4, 1, -1);
      repeat (3) send_frame(4, -1, -1);
      check("relock", 64'(locked_o), 64'd1);
      check("err_relock", 64'(err_cnt_o), 64'd1);

      // Bad period + 5 lines in one frame, then each fault alone.
      send_frame(5, -1, 3);
      send_frame(5, -1, -1);
      send_frame(4, -1, 3);
      send_frame(4, -1, -1);
      check("err_each", 64'(err_cnt_o), 64'd4);

      // Saturation of the error counter.
      repeat (300) send_frame(1, -1, -1);
      repeat (3) send_frame(4, -1, -1);
      check("err_sat", 64'(err_cnt_o), 64'd255);
      check("lock_after_sat", 64'(locked_o), 64'd1);

      // Reset mid-line while locked.
      sb_en = 1'b0;
      q.delete();
      send_line(1'b0, 16, 8, 0, 1'b0, 0, 9);
      check("lock_pre_rst", 64'(locked_o), 64'd1);
      rst_i = 1'b1;
      drive(0, 0, 1, 24'h5a5a5a, 12'd0, 12'd0, 0);
      check("mid_rst_outs", 64'({vs_o, hs_o, de_o, data_o, x_o, y_o, sof_o, eol_o, locked_o,
                                 err_cnt_o}), 64'd0);
      rst_i = 1'b0;
      send_line(1'b0, 16, 8, 0, 1'b0, 10, 16);
      m_state = 0; m_good = 0; m_err = 0; m_prev_bad = 1'b0;
      send_line(1'b0, 16, 0, 0, 1'b0, 0, 16);
      sb_en = 1'b1;
      send_frame(4, -1, -1);
      send_frame(4, -1, -1);
      check("no_lock_2vs", 64'(locked_o), 64'd0);
      send_frame(4, -1, -1);
      check("lock_3vs", 64'(locked_o), 64'd1);
      send_frame(4, -1, -1);
      repeat (4) drive(0, 0, 0, 24'd0, 12'd0, 12'd0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
